mult_secuencial: RTL and testbench

Sequential signed reconstructor, the inverse of the combinational divider Div. From cociente, divisor and residuo it computes dividendo = cociente*divisor + residuo. It uses a radix-2 shift-add multiplier on operand magnitudes, followed by a sign-fix and add step. It sits beside Div in the lab-3 ALU datapath, where it checks division results and serves as the multiply path, with a start/busy/done handshake.

---
 rtl/mult_secuencial.sv | 145 ++++++++++++++
 tb/tb_mult_secuencial.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_secuencial.sv
// Sequential signed reconstructor: dividendo = cociente*divisor + residuo (inverse of Div).
// Latency: done pulses N+1 edges after the accepting edge; one operation every N+3 cycles.
// Backpressure: start is only sampled in IDLE; starts while busy are dropped, never queued.
//
// Ports:
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   start           operation request, sampled only while idle
//   cociente        signed multiplicand
//   divisor         signed multiplier
//   residuo         signed addend
//   busy            high from the cycle after acceptance until done deasserts
//   done            one-cycle pulse, result valid
//   dividendo       low N bits of the signed result, held until the next result
//   desbordamiento  full result does not fit in N-bit signed
module mult_secuencial #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] cociente,
    input  logic [N-1:0] divisor,
    input  logic [N-1:0] residuo,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] dividendo,
    output logic         desbordamiento
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_SIGN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [N-1:0]    r_mag_a;
    logic [N-1:0]    r_mag_b;
    logic [N-1:0]    r_res;
    logic            r_neg;
    logic [2*N-1:0]  r_acc;
    logic [CW-1:0]   r_cnt;
    logic [N-1:0]    r_dividendo;
    logic            r_desbordamiento;

    logic [N-1:0]    w_abs_a;
    logic [N-1:0]    w_abs_b;
    logic [2*N-1:0]  w_addend;
    logic [2*N:0]    w_acc_ext;
    logic [2*N:0]    w_res_ext;
    logic [2*N:0]    w_full;
    logic [N+1:0]    w_top;
    logic            w_ovf;

    // Magnitudes as unsigned N-bit: negating -2^(N-1) wraps to 2^(N-1), which is
    // exactly the correct unsigned magnitude.
    assign w_abs_a = cociente[N-1] ? (-cociente) : cociente;
    assign w_abs_b = divisor[N-1]  ? (-divisor)  : divisor;

    // Partial product for the current multiplier bit.
    assign w_addend = {{N{1'b0}}, r_mag_a} << r_cnt;

    // Sign fix and addend at 2N+1 bits so neither the negation nor the add can wrap.
    assign w_acc_ext = {1'b0, r_acc};
    assign w_res_ext = {{(N+1){r_res[N-1]}}, r_res};
    assign w_full    = (r_neg ? (-w_acc_ext) : w_acc_ext) + w_res_ext;

    // The result fits in N-bit signed iff bits [2N:N-1] are all copies of the sign.
    assign w_top = w_full[2*N:N-1];
    assign w_ovf = !((&w_top) || !(|w_top));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_MUL;
            S_MUL:   if (r_cnt == CW'(N - 1)) w_next = S_SIGN;
            S_SIGN:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs: busy covers MUL/SIGN/DONE, done is exactly the DONE state.
    always_comb begin
        busy           = (r_state != S_IDLE);
        done           = (r_state == S_DONE);
        dividendo      = r_dividendo;
        desbordamiento = r_desbordamiento;
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mag_a          <= '0;
            r_mag_b          <= '0;
            r_res            <= '0;
            r_neg            <= 1'b0;
            r_acc            <= '0;
            r_cnt            <= '0;
            r_dividendo      <= '0;
            r_desbordamiento <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_res   <= residuo;
                        r_mag_a <= w_abs_a;
                        r_mag_b <= w_abs_b;
                        r_neg   <= cociente[N-1] ^ divisor[N-1];
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_MUL: begin
                    if (r_mag_b[0]) begin
                        r_acc <= r_acc + w_addend;
                    end
                    r_mag_b <= r_mag_b >> 1;
                    r_cnt   <= r_cnt + CW'(1);
                end
                S_SIGN: begin
                    r_dividendo      <= w_full[N-1:0];
                    r_desbordamiento <= w_ovf;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_secuencial.sv
// Directed bench for mult_secuencial (N=8): hand-computed results, latency and handshake.
// Latency: each directed operation is bounded to 40 cycles before it counts as a failure.
// Backpressure: exercises start held high and start pulsed while busy.
module tb_mult_secuencial;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] cociente;
    logic [7:0] divisor;
    logic [7:0] residuo;
    logic       busy;
    logic       done;
    logic [7:0] dividendo;
    logic       desbordamiento;

    int n_cmp;
    int n_err;

    mult_secuencial #(.N(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .cociente       (cociente),
        .divisor        (divisor),
        .residuo        (residuo),
        .busy           (busy),
        .done           (done),
        .dividendo      (dividendo),
        .desbordamiento (desbordamiento)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One operation: drive operands, scramble inputs right after acceptance,
    // optionally pulse start mid-MUL, then check latency, result and the pulse shape.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] r, input logic [7:0] exp_d, input logic exp_o,
                          input bit inj);
        int lat;
        bit seen;
        @(negedge clk);
        cociente = a;
        divisor  = b;
        residuo  = r;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        cociente = ~a;
        divisor  = b + 8'd1;
        residuo  = r ^ 8'h55;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        lat  = 0;
        seen = 0;
        while (!seen && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (inj && lat == 3) start = 1'b1;
            if (inj && lat == 4) start = 1'b0;
            if (done) seen = 1;
        end
        check({tag, "_lat"}, 32'(lat), 32'd9);
        check({tag, "_div"}, 32'(dividendo), 32'(exp_d));
        check({tag, "_ovf"}, 32'(desbordamiento), 32'(exp_o));
        @(posedge clk);
        #1;
        check({tag, "_done1"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_hold"}, 32'(dividendo), 32'(exp_d));
        if (inj) begin
            @(posedge clk);
            #1;
            check({tag, "_noqueue"}, 32'(busy), 32'd0);
        end
    endtask

    // Expected results of the back-to-back run: 3*4+1, -5*3+2, 10*10+0
    logic [7:0] bb_a [3];
    logic [7:0] bb_b [3];
    logic [7:0] bb_r [3];
    logic [7:0] bb_e [3];

    initial begin
        int cyc;
        int k;
        int d;
        int last_acc;
        logic prev_busy;
        logic prev_done;

        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        cociente = '0;
        divisor  = '0;
        residuo  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_div", 32'(dividendo), 32'd0);
        check("rst_ovf", 32'(desbordamiento), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("basic", 8'd7, 8'd2, 8'd1, 8'h0F, 1'b0, 0);

        // Reset mid-MUL
        @(negedge clk);
        cociente = 8'd9;
        divisor  = 8'd9;
        residuo  = 8'd0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_div", 32'(dividendo), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("postrst_busy", 32'(busy), 32'd0);
        check("postrst_done", 32'(done), 32'd0);
        check("postrst_div", 32'(dividendo), 32'd0);
        check("postrst_ovf", 32'(desbordamiento), 32'd0);
        run_op("fresh", 8'd3, 8'd3, 8'd3, 8'h0C, 1'b0, 0);

        run_op("neg7x2m1", 8'hF9, 8'd2, 8'hFF, 8'hF1, 1'b0, 0);
        run_op("m2xm1", 8'hFE, 8'hFF, 8'h00, 8'h02, 1'b0, 0);
        run_op("p2xm1", 8'h02, 8'hFF, 8'h00, 8'hFE, 1'b0, 0);
        run_op("minxm1", 8'h80, 8'hFF, 8'h00, 8'h80, 1'b1, 0);
        run_op("maxp1", 8'h7F, 8'h01, 8'h01, 8'h80, 1'b1, 0);
        run_op("minx1", 8'h80, 8'h01, 8'h00, 8'h80, 1'b0, 0);
        run_op("zero_a", 8'h00, 8'h01, 8'h00, 8'h00, 1'b0, 0);
        run_op("zero_b", 8'h05, 8'h00, 8'hFD, 8'hFD, 1'b0, 0);
        run_op("midstart", 8'd6, 8'd3, 8'd0, 8'h12, 1'b0, 1);

        // Start held high: one operation per 11 cycles using the operands
        // present at each accepting edge.
        bb_a[0] = 8'd3;  bb_b[0] = 8'd4;  bb_r[0] = 8'd1;  bb_e[0] = 8'h0D;
        bb_a[1] = 8'hFB; bb_b[1] = 8'd3;  bb_r[1] = 8'd2;  bb_e[1] = 8'hF3;
        bb_a[2] = 8'd10; bb_b[2] = 8'd10; bb_r[2] = 8'd0;  bb_e[2] = 8'h64;
        @(negedge clk);
        cociente  = bb_a[0];
        divisor   = bb_b[0];
        residuo   = bb_r[0];
        start     = 1'b1;
        k         = 0;
        d         = 0;
        last_acc  = -1;
        prev_busy = 1'b0;
        prev_done = 1'b0;
        for (cyc = 0; cyc < 60 && d < 3; cyc++) begin
            @(posedge clk);
            #1;
            if (busy && !prev_busy) begin
                if (last_acc >= 0) check("b2b_period", 32'(cyc - last_acc), 32'd11);
                last_acc = cyc;
                k++;
                if (k < 3) begin
                    cociente = bb_a[k];
                    divisor  = bb_b[k];
                    residuo  = bb_r[k];
                end else begin
                    cociente = 8'h11;
                    divisor  = 8'h22;
                    residuo  = 8'h33;
                end
            end
            if (done) begin
                check("b2b_pulse", 32'(prev_done), 32'd0);
                check("b2b_div", 32'(dividendo), 32'(bb_e[d]));
                d++;
            end
            prev_busy = busy;
            prev_done = done;
        end
        check("b2b_count", 32'(d), 32'd3);
        start = 1'b0;
        repeat (15) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
